axis_frame_host: RTL and testbench
==================================

# axis_frame_host

Host-side AXI-Stream frame driver for the CNN accelerator's stream interface. It holds one input frame in a local TX buffer and streams it out as an AXIS master with `m_last` on the final beat. It then accepts the result frame as an AXIS slave into a local RX buffer and signals completion. It sits between the host/test logic and the accelerator's stream wrapper, and drives the opposite end of both of that wrapper's streams.

## Interface
- `DATA_WIDTH`, 32: width of each stream word.
- `TX_DATA_NUM`, 8: words per outgoing frame; must be ≥ 2.
- `RX_DATA_NUM`, 4: words per returning frame; must be ≥ 2.
- `TIMEOUT_CYCLES`, 1024: receive idle limit; used only with the macro.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begins one frame transaction; sampled only in IDLE.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse at the end of a transaction.
- `len_err`  out  1  sticky: returning frame length or `s_last` mismatch.
- `timeout`  out  1  sticky: receive watchdog expired.
- `tx_wr`  in  1  host write strobe into the TX buffer.
- `tx_adr`  in  clog2(TX_DATA_NUM)  TX buffer write address.
- `tx_data`  in  DATA_WIDTH  TX buffer write data.
- `rx_adr`  in  clog2(RX_DATA_NUM)  RX buffer read address.
- `rx_data`  out  DATA_WIDTH  RX buffer read data, combinational.
- `m_data`, `m_valid`, `m_last`  out  DATA_WIDTH/1/1  outgoing AXIS master.
- `m_ready`  in  1  outgoing AXIS master ready.
- `s_data`, `s_valid`, `s_last`  in  DATA_WIDTH/1/1  returning AXIS slave.
- `s_ready`  out  1  returning AXIS slave ready.

## Operation
- State machine: IDLE → SEND → RECV → DONE → IDLE.
- **IDLE**
  - `tx_wr` writes `tx_data` to TX[`tx_adr`].
  - `start` clears `len_err` and `timeout`, clears the TX and RX counters, and moves to SEND.
- **SEND**
  - `m_valid` = 1.
  - `m_data` = TX[txCnt].
  - `m_last` = (txCnt == TX_DATA_NUM-1).
  - A handshake (`m_valid` & `m_ready`) increments txCnt.
  - The handshake on the last beat moves to RECV.
  - `tx_wr` is ignored in this state.
- **RECV**
  - `s_ready` = 1.
  - On `s_valid`: write `s_data` to RX[rxCnt] and increment rxCnt.
  - Beat with rxCnt == RX_DATA_NUM-1:
    - Goes to DONE.
    - Sets `len_err` if `s_last` = 0.
  - Beat with `s_last` = 1 and rxCnt < RX_DATA_NUM-1:
    - The word is still stored.
    - Sets `len_err` and goes to DONE (early end).
- **DONE**: `done` = 1 for exactly one cycle, then IDLE. `s_ready` = 0 here, so no extra beats are accepted.
- **RX read port**: `rx_adr`/`rx_data` are readable in every state.
- **Counter widths**: counters are clog2(N) bits and never wrap inside a frame; each is cleared on `start`.

## Timing
- **Reset values**: state IDLE; `busy`, `done`, `len_err`, `timeout`, `m_valid`, `m_last`, `s_ready` all 0; counters 0. Buffer contents are not reset.
- **Reset mid-frame**: immediate return to IDLE, and the frame is abandoned. The downstream peer sees `m_valid` drop, which is permitted only because of reset.
- **Start latency**: `start` high in IDLE at edge N gives `m_valid` = 1 from cycle N+1.
- **Beat rate**: one beat per cycle when `m_ready` is held high.
- **AXIS master rule**: while `m_valid` & !`m_ready`, `m_data` and `m_last` stay stable. This follows because txCnt advances only on a handshake.
- **RECV entry**: `s_ready` rises the cycle after the last TX handshake. Minimum transaction with both sides always ready: 1 + TX_DATA_NUM + RX_DATA_NUM + 1 cycles from `start` to the `done` pulse.
- **Status timing**: `len_err` and `timeout` are valid by the cycle `done` is high, and hold until the next accepted `start`.
- **TX write collision**: `tx_wr` in the same cycle as `start` is still written, and its data is visible from SEND cycle 1.

## Configuration
- Macro: `AXIS_FRAME_HOST_TIMEOUT_EN`.
- **Defined**:
  - A watchdog counter runs in RECV and clears on every `s_valid` beat.
  - When it reaches TIMEOUT_CYCLES-1: set `timeout`, go to DONE, and pulse `done`.
- **Undefined**:
  - No watchdog logic is built.
  - `timeout` is tied to 0.
  - RECV waits indefinitely.

## Structure
- **Package `axis_frame_host_pkg`**:
  - State enum: IDLE = 0, SEND = 1, RECV = 2, DONE = 3 (2 bits).
  - Default parameter constants.
  - Address-width helper based on clog2.
- **Sub-module `frame_buffer`**:
  - Synchronous write, asynchronous read, no reset.
  - Instantiated twice: TX with depth TX_DATA_NUM, RX with depth RX_DATA_NUM.
- **Top level**: FSM, counters, watchdog and AXIS output muxing stay in this module.

## Test plan
- **Basic transaction**: load TX with 0x10..0x17; `start`; `m_ready` and `s_valid` held 1 with `s_data` 0xA0..0xA3, `s_last` on the 4th beat → `m_data` 0x10..0x17 with `m_last` only on 0x17; RX reads 0xA0..0xA3; `done` 14 cycles after `start`; `len_err` = 0.
- **Backpressure**: `m_ready` toggles 1,0,0,1,… → each word is sent exactly once; `m_data` is stable during every stall.
- **Early last**: `s_last` on the 2nd beat → `len_err` = 1; `done` pulses; RX[0..1] written; RX[2..3] unchanged.
- **Missing last**: 4 beats with `s_last` = 0 → `len_err` = 1; `done` pulses; `s_ready` = 0 on the 5th offered beat.
- **Reset mid-SEND**: `rst` after 3 beats → all outputs 0 the same cycle; a new `start` resends from word 0.
- **Timeout** (macro defined, TIMEOUT_CYCLES = 16): no `s_valid` after SEND → `timeout` = 1 and `done` 16 cycles after RECV entry.

Source files
------------

// File: rtl/axis_frame_host_pkg.sv
// Shared types and defaults for the axis_frame_host frame driver.
package axis_frame_host_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_TX_DATA_NUM    = 8;
  localparam int DEF_RX_DATA_NUM    = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  function automatic int adr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/frame_buffer.sv
// Small word buffer: synchronous write, asynchronous read, no reset.
module frame_buffer
  import axis_frame_host_pkg::*;
#(
  parameter int DW    = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_TX_DATA_NUM
) (
  input  logic                    clk,
  input  logic                    wr,
  input  logic [adr_w(DEPTH)-1:0] wr_adr,
  input  logic [DW-1:0]           wr_data,
  input  logic [adr_w(DEPTH)-1:0] rd_adr,
  output logic [DW-1:0]           rd_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr) mem[wr_adr] <= wr_data;
  end

  assign rd_data = mem[rd_adr];

endmodule

// File: rtl/axis_frame_host.sv
// Host-side AXIS frame driver: sends one TX frame, collects one RX frame.
// Define AXIS_FRAME_HOST_TIMEOUT_EN to build the receive watchdog.
module axis_frame_host
  import axis_frame_host_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TX_DATA_NUM    = DEF_TX_DATA_NUM,
  parameter int RX_DATA_NUM    = DEF_RX_DATA_NUM,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          len_err,
  output logic                          timeout,
  input  logic                          tx_wr,
  input  logic [adr_w(TX_DATA_NUM)-1:0] tx_adr,
  input  logic [DATA_WIDTH-1:0]         tx_data,
  input  logic [adr_w(RX_DATA_NUM)-1:0] rx_adr,
  output logic [DATA_WIDTH-1:0]         rx_data,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_valid,
  output logic                          m_last,
  input  logic                          m_ready,
  input  logic [DATA_WIDTH-1:0]         s_data,
  input  logic                          s_valid,
  input  logic                          s_last,
  output logic                          s_ready
);

  localparam int TX_AW = adr_w(TX_DATA_NUM);
  localparam int RX_AW = adr_w(RX_DATA_NUM);
  localparam logic [TX_AW-1:0] TX_LAST = TX_AW'(TX_DATA_NUM - 1);
  localparam logic [RX_AW-1:0] RX_LAST = RX_AW'(RX_DATA_NUM - 1);

  state_e           state_q, state_d;
  logic [TX_AW-1:0] tx_cnt_q, tx_cnt_d;
  logic [RX_AW-1:0] rx_cnt_q, rx_cnt_d;
  logic             len_err_q, len_err_d;
  logic [DATA_WIDTH-1:0] tx_rd;

`ifdef AXIS_FRAME_HOST_TIMEOUT_EN
  localparam int WD_W = adr_w(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
`endif

  frame_buffer #(.DW(DATA_WIDTH), .DEPTH(TX_DATA_NUM)) u_tx_buf (
    .clk     (clk),
    .wr      (tx_wr && (state_q == IDLE)),
    .wr_adr  (tx_adr),
    .wr_data (tx_data),
    .rd_adr  (tx_cnt_q),
    .rd_data (tx_rd)
  );

  frame_buffer #(.DW(DATA_WIDTH), .DEPTH(RX_DATA_NUM)) u_rx_buf (
    .clk     (clk),
    .wr      (s_valid && (state_q == RECV)),
    .wr_adr  (rx_cnt_q),
    .wr_data (s_data),
    .rd_adr  (rx_adr),
    .rd_data (rx_data)
  );

  always_comb begin
    state_d   = state_q;
    tx_cnt_d  = tx_cnt_q;
    rx_cnt_d  = rx_cnt_q;
    len_err_d = len_err_q;
`ifdef AXIS_FRAME_HOST_TIMEOUT_EN
    wd_d      = wd_q;
    timeout_d = timeout_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SEND;
          tx_cnt_d  = '0;
          rx_cnt_d  = '0;
          len_err_d = 1'b0;
`ifdef AXIS_FRAME_HOST_TIMEOUT_EN
          wd_d      = '0;
          timeout_d = 1'b0;
`endif
        end
      end
      SEND: begin
        if (m_ready) begin
          if (tx_cnt_q == TX_LAST) state_d = RECV;
          else tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      RECV: begin
        if (s_valid) begin
`ifdef AXIS_FRAME_HOST_TIMEOUT_EN
          wd_d = '0;
`endif
          if (rx_cnt_q == RX_LAST) begin
            state_d = DONE;
            if (!s_last) len_err_d = 1'b1;
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
            // Early end: word already stored, frame closed short.
            if (s_last) begin
              len_err_d = 1'b1;
              state_d   = DONE;
            end
          end
        end
`ifdef AXIS_FRAME_HOST_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      len_err_q <= len_err_d;
    end
  end

`ifdef AXIS_FRAME_HOST_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign len_err = len_err_q;
  assign m_valid = (state_q == SEND);
  assign m_last  = m_valid && (tx_cnt_q == TX_LAST);
  assign m_data  = m_valid ? tx_rd : '0;
  assign s_ready = (state_q == RECV);

endmodule

// File: tb/tb_axis_frame_host.sv
// Scoreboard bench for axis_frame_host: directed frames, monitor on negedge.
module tb_axis_frame_host;

  localparam int DW  = 32;
  localparam int TXN = 8;
  localparam int RXN = 4;
  localparam int TOC = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, len_err, timeout;
  logic          tx_wr;
  logic [2:0]    tx_adr;
  logic [DW-1:0] tx_data;
  logic [1:0]    rx_adr;
  logic [DW-1:0] rx_data;
  logic [DW-1:0] m_data;
  logic          m_valid, m_last;
  logic          m_ready = 1'b1;
  logic [DW-1:0] s_data;
  logic          s_valid, s_last;
  logic          s_ready;

  axis_frame_host #(
    .DATA_WIDTH(DW), .TX_DATA_NUM(TXN),
    .RX_DATA_NUM(RXN), .TIMEOUT_CYCLES(TOC)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done),
    .len_err(len_err), .timeout(timeout),
    .tx_wr(tx_wr), .tx_adr(tx_adr), .tx_data(tx_data),
    .rx_adr(rx_adr), .rx_data(rx_data),
    .m_data(m_data), .m_valid(m_valid),
    .m_last(m_last), .m_ready(m_ready),
    .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t         exp_q[$];
  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] tx_model [TXN];
  logic [DW-1:0] rx_model [RXN];
  bit            bp_en = 1'b0;
  int            bp_k = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Backpressure pattern 1,0,0 repeating when enabled.
  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      m_ready = (bp_k % 3 == 0);
      bp_k++;
    end else begin
      m_ready = 1'b1;
    end
  end

  logic          stall = 1'b0;
  logic [DW-1:0] stall_d;
  logic          stall_l;

  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (stall && m_valid) begin
        chk("stall_data", m_data, stall_d);
        chk("stall_last", 32'(m_last), 32'(stall_l));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          b = exp_q.pop_front();
          chk("m_data", m_data, b.d);
          chk("m_last", 32'(m_last), 32'(b.l));
        end
      end
      stall   = m_valid && !m_ready;
      stall_d = m_data;
      stall_l = m_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_tx(input int a, input logic [DW-1:0] d);
    tx_wr   = 1'b1;
    tx_adr  = 3'(a);
    tx_data = d;
    tick();
    tx_wr = 1'b0;
  endtask

  task automatic load_tx(input logic [DW-1:0] base);
    for (int i = 0; i < TXN; i++) begin
      tx_model[i] = base + DW'(i);
      wr_tx(i, base + DW'(i));
    end
  endtask

  task automatic push_tx();
    for (int i = 0; i < TXN; i++)
      exp_q.push_back('{tx_model[i], (i == TXN - 1)});
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic run_frame(input int n_rx, input int last_at,
                           input logic [DW-1:0] rbase, input int n_wr,
                           input logic exp_le, input int exp_cyc,
                           input bit send_wr);
    int cyc;
    int idx = 0;
    bit acc;
    bit got = 1'b0;
    s_valid = (n_rx > 0);
    s_data  = rbase;
    s_last  = (last_at == 0);
    start   = 1'b1;
    for (cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        chk("len_err_clr", 32'(len_err), 0);
        chk("busy", 32'(busy), 1);
      end
      if (done) begin
        got = 1'b1;
        break;
      end
      acc = s_valid && s_ready;
      tick();
      start = 1'b0;
      tx_wr = 1'b0;
      if (send_wr && cyc == 2) begin
        tx_wr   = 1'b1;
        tx_adr  = 3'd5;
        tx_data = 32'hDEAD_BEEF;
      end
      if (acc) begin
        idx++;
        if (idx < n_rx) begin
          s_data = rbase + DW'(idx);
          s_last = (idx == last_at);
        end else begin
          s_valid = 1'b0;
        end
      end
    end
    chk("done_seen", 32'(got), 1);
    // Counted inclusively: the start cycle is cycle 1.
    if (exp_cyc > 0) chk("done_cycles", cyc + 1, exp_cyc);
    chk("len_err", 32'(len_err), 32'(exp_le));
    chk("s_ready_in_done", 32'(s_ready), 0);
    chk("timeout_off", 32'(timeout), 0);
    tick();
    start   = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("done_one_cycle", 32'(done), 0);
    chk("busy_idle", 32'(busy), 0);
    chk("tx_all_sent", exp_q.size(), 0);
    if (!got) pulse_rst();
    for (int i = 0; i < n_wr; i++) rx_model[i] = rbase + DW'(i);
    for (int i = 0; i < RXN; i++) begin
      rx_adr = 2'(i);
      #1;
      chk("rx_data", rx_data, rx_model[i]);
    end
    tick();
  endtask

  initial begin
    int rc;
    int cyc;
    bit got;
    rst     = 1'b1;
    start   = 1'b0;
    tx_wr   = 1'b0;
    tx_adr  = '0;
    tx_data = '0;
    rx_adr  = '0;
    s_data  = '0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_len_err", 32'(len_err), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_last", 32'(m_last), 0);
    chk("rst_s_ready", 32'(s_ready), 0);
    rst = 1'b0;
    tick();

    // Basic frame; word 0 rewritten in the start cycle.
    load_tx(32'h10);
    wr_tx(0, 32'hEE);
    tx_wr   = 1'b1;
    tx_adr  = 3'd0;
    tx_data = 32'h10;
    push_tx();
    run_frame(4, 3, 32'hA0, 4, 1'b0, 14, 1'b0);

    // Backpressure, plus a TX write during SEND that must be ignored.
    bp_en = 1'b1;
    bp_k  = 0;
    load_tx(32'h20);
    push_tx();
    run_frame(4, 3, 32'hB0, 4, 1'b0, 0, 1'b1);
    bp_en = 1'b0;
    tick();

    // Early s_last on 2nd beat: RX[2..3] keep B2,B3.
    push_tx();
    run_frame(4, 1, 32'hC0, 2, 1'b1, 0, 1'b0);

    // No s_last; 5th beat offered must be refused.
    push_tx();
    run_frame(5, -1, 32'hD0, 4, 1'b1, 0, 1'b0);

    // Reset after 3 beats, then full resend.
    load_tx(32'h30);
    push_tx();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_m_valid", 32'(m_valid), 0);
    chk("mid_rst_m_last", 32'(m_last), 0);
    chk("mid_rst_m_data", m_data, 0);
    chk("mid_rst_s_ready", 32'(s_ready), 0);
    chk("mid_rst_left", exp_q.size(), TXN - 3);
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    push_tx();
    run_frame(4, 3, 32'hE0, 4, 1'b0, 14, 1'b0);

    // Receive side silent.
    push_tx();
    start = 1'b1;
    rc  = -1;
    got = 1'b0;
`ifdef AXIS_FRAME_HOST_TIMEOUT_EN
    for (cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (s_ready && rc < 0) rc = cyc;
      if (done) begin
        got = 1'b1;
        break;
      end
      tick();
      start = 1'b0;
    end
    chk("to_done_seen", 32'(got), 1);
    chk("to_latency", cyc - rc, TOC);
    chk("to_flag", 32'(timeout), 1);
    chk("to_len_err", 32'(len_err), 0);
    tick();
    chk("to_sticky", 32'(timeout), 1);
    if (!got) pulse_rst();
`else
    for (cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      tick();
      start = 1'b0;
    end
    chk("wait_no_done", 32'(got), 0);
    chk("wait_busy", 32'(busy), 1);
    chk("wait_s_ready", 32'(s_ready), 1);
    chk("wait_timeout", 32'(timeout), 0);
    pulse_rst();
`endif
    chk("final_tx_q", exp_q.size(), 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
